// File: rtl/seven_seg_bcd_converter.sv
// seven_seg_bcd_converter: sequential shift-add-3 (double-dabble) binary-to-BCD converter
// Sits between the seven-seg peripheral register and the per-digit hex decoders.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-high reset
//   bin_in   - WIDTH-bit binary value to convert
//   start    - conversion request, sampled only while idle
//   busy     - high while a conversion is in flight
//   done     - one-cycle pulse when bcd_out/overflow are updated
//   bcd_out  - packed BCD result, ones digit in [3:0]
//   overflow - a digit at index >= SHOWN_DIGITS of the last result is non-zero
// Optional feature: define SEVEN_SEG_BCD_AUTO_CONVERT_EN to start a conversion
// automatically whenever bin_in differs from the last value sampled.
module seven_seg_bcd_converter #(
    parameter int WIDTH        = 16,
    parameter int DIGITS       = 5,
    parameter int SHOWN_DIGITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int TW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   work_q, work_d, adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            go;
`ifdef SEVEN_SEG_BCD_AUTO_CONVERT_EN
    logic [WIDTH-1:0] last_q, last_d;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
`ifdef SEVEN_SEG_BCD_AUTO_CONVERT_EN
        last_d  = last_q;
        go      = start || (bin_in != last_q);
`else
        go      = start;
`endif
        // Field-local add-3 on every BCD digit; no carry crosses a digit boundary.
        adj = work_q;
        for (int i = 0; i < DIGITS; i++)
            if (adj[WIDTH+4*i +: 4] >= 4'd5)
                adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = SHIFT;
                    work_d  = {{BW{1'b0}}, bin_in};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef SEVEN_SEG_BCD_AUTO_CONVERT_EN
                    last_d  = bin_in;
`endif
                end
            end
            SHIFT: begin
                work_d  = adj << 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FINISH : SHIFT;
            end
            FINISH: begin
                state_d = IDLE;
                bcd_d   = work_q[TW-1:WIDTH];
                ovf_d   = |work_q[TW-1:WIDTH+4*SHOWN_DIGITS];
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef SEVEN_SEG_BCD_AUTO_CONVERT_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
`ifdef SEVEN_SEG_BCD_AUTO_CONVERT_EN
            last_q  <= last_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_seven_seg_bcd_converter.sv
// tb_seven_seg_bcd_converter: directed self-checking bench for seven_seg_bcd_converter
module tb_seven_seg_bcd_converter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [19:0] bcd_out;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seven_seg_bcd_converter dut (
        .clock(clock), .reset(reset), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic conv(input logic [15:0] v, input logic [19:0] eb, input logic eo, input string tag);
        int n;
        int bad_busy;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        n = 0;
        bad_busy = 0;
        do begin
            tick();
            n++;
            if (!done && !busy) bad_busy++;
        end while (!done && n < 40);
        chk({tag, "_latency"}, n, 17);
        chk({tag, "_busy_gap"}, bad_busy, 0);
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(eb));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_bcd_hold"}, 32'(bcd_out), 32'(eb));
    endtask

    initial begin
        int n;
        int dones;
        int first;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        conv(16'h0000, 20'h00000, 1'b0, "zero");
        conv(16'h2000, 20'h08192, 1'b0, "v8192");
        conv(16'h270F, 20'h09999, 1'b0, "v9999");
        conv(16'hFFFF, 20'h65535, 1'b1, "vmax");
        conv(16'h0001, 20'h00001, 1'b0, "one");

        bin_in = 16'h1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        bin_in = 16'h0005;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = 16'hABCD;
        n = 5;
        dones = 0;
        first = 0;
        repeat (25) begin
            tick();
            n++;
            if (done) begin
                dones++;
                if (first == 0) first = n;
            end
            if (n == 16) bin_in = 16'h1234;
        end
        chk("midflight_dones", dones, 1);
        chk("midflight_latency", first, 17);
        chk("midflight_bcd", 32'(bcd_out), 32'h04660);

        bin_in = 16'h2710;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (8) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_bcd", 32'(bcd_out), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        bin_in = 16'h0000;
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        repeat (20) begin
            tick();
            if (done) dones++;
        end
        chk("after_rst_no_done", dones, 0);
        chk("after_rst_bcd", 32'(bcd_out), 32'd0);
        conv(16'h2710, 20'h10000, 1'b1, "v10000");

`ifdef SEVEN_SEG_BCD_AUTO_CONVERT_EN
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bin_in = 16'h0042;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
        chk("auto_latency", n, 17);
        chk("auto_bcd", 32'(bcd_out), 32'h00066);
        dones = 0;
        repeat (30) begin
            tick();
            if (done) dones++;
        end
        chk("auto_hold_no_done", dones, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
